// File: rtl/capture_sequencer_pkg.sv
// Shared constants and types for the logic-analyzer capture sequencer.
// Project-wide `define constants (holdoff width, default address width and
// the CAP_* state encodings) live at the top of this file so that every
// file compiled after it sees them. Optional build macro used by the top:
// ILA_TRIGGER_SYNC_EN.
`ifndef CAPTURE_SEQUENCER_DEFINES
`define CAPTURE_SEQUENCER_DEFINES
`define HOLDOFF_WIDTH  8
`define CAP_ADDR_WIDTH 4
`define CAP_IDLE       3'd0
`define CAP_FILL       3'd1
`define CAP_PRIMED     3'd2
`define CAP_HOLDOFF    3'd3
`define CAP_STOPPED    3'd4
`define CAP_READOUT    3'd5
`endif

package capture_sequencer_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = `CAP_IDLE,
        ST_FILL    = `CAP_FILL,
        ST_PRIMED  = `CAP_PRIMED,
        ST_HOLDOFF = `CAP_HOLDOFF,
        ST_STOPPED = `CAP_STOPPED,
        ST_READOUT = `CAP_READOUT
    } cap_state_t;

    // States in which the sample RAM is being written.
    function automatic logic is_writing(input cap_state_t s);
        return (s == ST_FILL) || (s == ST_PRIMED) || (s == ST_HOLDOFF);
    endfunction

endpackage

// File: rtl/capture_sequencer_trigger_conditioner.sv
// Trigger conditioner: two-flop synchroniser followed by a rising-edge
// detector. A level held high produces a single one-cycle pulse, two cycles
// after the input rose.
module trigger_conditioner (
    input  logic clk,
    input  logic reset,
    input  logic i_trigger,
    output logic o_pulse
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    // Synchronise the raw trigger and keep one cycle of history for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= i_trigger;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign o_pulse = sync2 & ~sync_prev;

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: capture controller for the internal logic analyzer.
// Walks the sample-RAM write pointer through FILL, PRIMED and HOLDOFF,
// records where the trigger sample landed, then reads the whole buffer back
// oldest-first over a valid/ready port.
// Build macro ILA_TRIGGER_SYNC_EN: when defined, i_trigger goes through a
// synchroniser and rising-edge detector; otherwise it is used directly as a level.
//
// Readout handshake: an address transfers on every cycle where o_rd_valid and
// i_rd_ready are both high. While o_rd_valid is high and i_rd_ready is low,
// o_rd_addr is held. o_rd_valid only drops without a transfer on abort or reset.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = `CAP_ADDR_WIDTH,
    parameter int HOLDOFF_WIDTH = `HOLDOFF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic                     i_trigger,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic                     i_rd_ready,
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic                     o_primed,
    output logic                     o_triggered,
    output logic                     o_stopped,
    output logic [ADDR_WIDTH-1:0]    o_trig_addr,
    output logic [ADDR_WIDTH-1:0]    o_rd_addr,
    output logic                     o_rd_valid,
    output logic                     o_done,
    output logic [STATE_WIDTH-1:0]   o_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CMP_W = (HOLDOFF_WIDTH > ADDR_WIDTH) ? HOLDOFF_WIDTH : ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CMP_W-1:0]      HOLD_MAX  = CMP_W'(DEPTH - 1);

    cap_state_t              state_q;
    cap_state_t              state_d;
    logic                    trig_eff;
    logic                    trig_take;
    logic [CMP_W-1:0]        holdoff_ext;
    logic [ADDR_WIDTH-1:0]   hold_sat;
    logic [ADDR_WIDTH-1:0]   hold_cnt;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   trig_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   rd_cnt;
    logic                    triggered;

`ifdef ILA_TRIGGER_SYNC_EN
    trigger_conditioner u_trigger_conditioner (
        .clk       (clk),
        .reset     (reset),
        .i_trigger (i_trigger),
        .o_pulse   (trig_eff)
    );
`else
    assign trig_eff = i_trigger;
`endif

    // Clamp the holdoff to D-1 so post-trigger writes never reach the trigger sample.
    assign holdoff_ext = CMP_W'(i_holdoff);
    assign hold_sat    = (holdoff_ext > HOLD_MAX) ? ADDR_LAST : holdoff_ext[ADDR_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state outputs; abort overrides every other event.
    always_comb begin
        state_d    = state_q;
        o_wr_en    = 1'b0;
        o_rd_valid = 1'b0;
        o_done     = 1'b0;
        trig_take  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_arm) state_d = ST_FILL;
            end
            ST_FILL: begin
                o_wr_en = 1'b1;
                if (wr_addr == ADDR_LAST) state_d = ST_PRIMED;
            end
            ST_PRIMED: begin
                o_wr_en = 1'b1;
                if (trig_eff) begin
                    trig_take = 1'b1;
                    state_d   = (hold_sat == '0) ? ST_STOPPED : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                o_wr_en = 1'b1;
                if (hold_cnt == ADDR_WIDTH'(1)) state_d = ST_STOPPED;
            end
            ST_STOPPED: begin
                state_d = ST_READOUT;
            end
            ST_READOUT: begin
                o_rd_valid = 1'b1;
                if (i_rd_ready && (rd_cnt == ADDR_LAST)) begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (i_abort) begin
            state_d   = ST_IDLE;
            trig_take = 1'b0;
            o_done    = 1'b0;
        end
    end

    // Write pointer, trigger record, holdoff countdown and readout pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr   <= '0;
            trig_addr <= '0;
            hold_cnt  <= '0;
            triggered <= 1'b0;
            rd_addr   <= '0;
            rd_cnt    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && i_arm) begin
                wr_addr <= '0;
            end else if (is_writing(state_q)) begin
                wr_addr <= wr_addr + 1'b1;
            end

            if (trig_take) begin
                trig_addr <= wr_addr;
                hold_cnt  <= hold_sat;
            end else if (state_q == ST_HOLDOFF) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            if (state_d == ST_IDLE) begin
                triggered <= 1'b0;
            end else if (trig_take) begin
                triggered <= 1'b1;
            end

            // The next write location holds the oldest sample once writing stops.
            if (state_q == ST_STOPPED) begin
                rd_addr <= wr_addr;
                rd_cnt  <= '0;
            end else if ((state_q == ST_READOUT) && i_rd_ready) begin
                rd_addr <= rd_addr + 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
            end
        end
    end

    assign o_wr_addr   = wr_addr;
    assign o_primed    = (state_q == ST_PRIMED);
    assign o_triggered = triggered;
    assign o_stopped   = (state_q == ST_STOPPED) || (state_q == ST_READOUT);
    assign o_trig_addr = trig_addr;
    assign o_rd_addr   = rd_addr;
    assign o_state     = state_q;

endmodule
